// File: rtl/btn_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter among NBTN button channels.
// Each latched press is sent as one ASCII byte (BASE_CHAR + channel index).
module btn_tx_scheduler #(
    parameter int unsigned NBTN      = 4,
    parameter logic [7:0]  BASE_CHAR = 8'h41,
    parameter int unsigned TO_CYC    = 2000000
) (
    input  logic            clk_100MHz,
    input  logic            reset_n,
    input  logic [NBTN-1:0] btn_tick,
    input  logic            clr_err,
    input  logic            tx_done_tick,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    output logic            busy,
    output logic [NBTN-1:0] pending,
    output logic [NBTN-1:0] overrun,
    output logic            tx_timeout
);

    localparam int unsigned PW = $clog2(NBTN);
    localparam int unsigned CW = $clog2(TO_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NBTN-1:0] pend_q, pend_d;
    logic [NBTN-1:0] ovr_q, ovr_d;
    logic            to_q, to_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic            start_q, busy_q;

    logic            any_c;
    logic            found_c;
    logic [PW-1:0]   idx_c;
    logic [NBTN-1:0] gnt_c;
    logic            to_set_c;

    // Round-robin search: first pending channel at or above rr_q, with wraparound.
    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        for (int unsigned k = 0; k < NBTN; k++) begin
            if (!found_c && pend_q[PW'((32'(rr_q) + k) % NBTN)]) begin
                found_c = 1'b1;
                idx_c   = PW'((32'(rr_q) + k) % NBTN);
            end
        end
    end

    assign any_c = |pend_q;
    assign gnt_c = (state_q == IDLE && any_c) ? (NBTN'(1) << idx_c) : '0;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        to_set_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_c) begin
                    state_d = SEND;
                    data_d  = BASE_CHAR + 8'(idx_c);
                    rr_d    = (idx_c == PW'(NBTN - 1)) ? '0 : idx_c + PW'(1);
                end
            end
            SEND: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (tx_done_tick) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(TO_CYC - 1)) begin
                    to_set_c = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new tick always wins over a grant-clear or an error-clear on the same edge.
    always_comb begin
        pend_d = btn_tick | (pend_q & ~gnt_c);
        ovr_d  = (btn_tick & pend_q & ~gnt_c) | (ovr_q & {NBTN{~clr_err}});
        to_d   = to_set_c | (to_q & ~clr_err);
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ovr_q   <= '0;
            to_q    <= 1'b0;
            rr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= BASE_CHAR;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            start_q <= (state_d == SEND);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign tx_start   = start_q;
    assign tx_data    = data_q;
    assign busy       = busy_q;
    assign pending    = pend_q;
    assign overrun    = ovr_q;
    assign tx_timeout = to_q;

endmodule

// File: tb/tb_btn_tx_scheduler.sv
// Self-checking bench for btn_tx_scheduler: vector table, corner-case sequences,
// and randomized traffic against a rule-level reference model.
module tb_btn_tx_scheduler;

    localparam int unsigned N    = 4;
    localparam int unsigned TO   = 16;
    localparam logic [7:0]  BASE = 8'h41;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] btn_tick;
    logic         clr_err;
    logic         tx_done_tick;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         busy;
    logic [N-1:0] pending;
    logic [N-1:0] overrun;
    logic         tx_timeout;

    btn_tx_scheduler #(.NBTN(N), .BASE_CHAR(BASE), .TO_CYC(TO)) dut (
        .clk_100MHz  (clk),
        .reset_n     (reset_n),
        .btn_tick    (btn_tick),
        .clr_err     (clr_err),
        .tx_done_tick(tx_done_tick),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .busy        (busy),
        .pending     (pending),
        .overrun     (overrun),
        .tx_timeout  (tx_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pending"}, 32'(pending), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_tx_start"}, 32'(tx_start), 0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'(BASE));
        chk({tag, "_tx_timeout"}, 32'(tx_timeout), 0);
    endtask

    typedef struct {
        logic [N-1:0] btn;
        logic         clr;
        logic         done;
        logic [N-1:0] e_pend;
        logic [N-1:0] e_ovr;
        logic         e_busy;
        logic         e_start;
        logic [7:0]   e_data;
    } vec_t;

    vec_t tbl[20];

    // Reference model state: pending/overrun sets, pointer, and transfer phase.
    bit [N-1:0] m_pend, m_ovr;
    bit         m_to;
    int         m_phase;   // 0 idle, 1 start cycle, 2 awaiting done
    int         m_cnt, m_rr;
    logic [7:0] m_data;

    task automatic model_reset();
        m_pend = '0; m_ovr = '0; m_to = 0; m_phase = 0; m_cnt = 0; m_rr = 0; m_data = BASE;
    endtask

    task automatic model_step(input logic [N-1:0] b, input logic c, input logic d);
        int         gidx = -1;
        bit [N-1:0] g = '0;
        bit         to_set = 0;
        if (m_phase == 0) begin
            for (int k = 0; k < int'(N); k++) begin
                int j;
                j = (m_rr + k) % int'(N);
                if (gidx < 0 && m_pend[j]) gidx = j;
            end
        end
        if (gidx >= 0) g[gidx] = 1'b1;
        case (m_phase)
            0: if (gidx >= 0) begin
                m_phase = 1;
                m_data  = BASE + 8'(gidx);
                m_rr    = (gidx + 1) % int'(N);
            end
            1: begin m_phase = 2; m_cnt = 0; end
            default: begin
                if (d) m_phase = 0;
                else if (m_cnt == int'(TO) - 1) begin to_set = 1; m_phase = 0; end
                else m_cnt++;
            end
        endcase
        for (int i = 0; i < int'(N); i++) begin
            m_ovr[i]  = (b[i] && m_pend[i] && !g[i]) || (m_ovr[i] && !c);
            m_pend[i] = b[i] || (m_pend[i] && !g[i]);
        end
        m_to = to_set || (m_to && !c);
    endtask

    task automatic model_check();
        chk("rnd_pending", 32'(pending), 32'(m_pend));
        chk("rnd_overrun", 32'(overrun), 32'(m_ovr));
        chk("rnd_busy", 32'(busy), 32'(m_phase != 0));
        chk("rnd_tx_start", 32'(tx_start), 32'(m_phase == 1));
        chk("rnd_tx_data", 32'(tx_data), 32'(m_data));
        chk("rnd_tx_timeout", 32'(tx_timeout), 32'(m_to));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int countdown;
        logic [N-1:0] b;
        logic c, d;

        tbl[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'h41};
        tbl[1]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h43};
        tbl[2]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h43};
        tbl[3]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'h43};
        tbl[4]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'h43};
        tbl[5]  = '{4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 8'h43};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1, 8'h41};
        tbl[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h41};
        tbl[8]  = '{4'b0010, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'h41};
        tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h42};
        tbl[10] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h42};
        tbl[11] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h42};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h42};
        tbl[13] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 8'h42};
        tbl[14] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 8'h44};
        tbl[15] = '{4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 8'h44};
        tbl[16] = '{4'b0000, 1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 8'h44};
        tbl[17] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h44};
        tbl[18] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h44};
        tbl[19] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h44};

        reset_n = 1'b0; btn_tick = '0; clr_err = 1'b0; tx_done_tick = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;

        for (int r = 0; r < 20; r++) begin
            btn_tick = tbl[r].btn; clr_err = tbl[r].clr; tx_done_tick = tbl[r].done;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_pending", r), 32'(pending), 32'(tbl[r].e_pend));
            chk($sformatf("vec%0d_overrun", r), 32'(overrun), 32'(tbl[r].e_ovr));
            chk($sformatf("vec%0d_busy", r), 32'(busy), 32'(tbl[r].e_busy));
            chk($sformatf("vec%0d_tx_start", r), 32'(tx_start), 32'(tbl[r].e_start));
            chk($sformatf("vec%0d_tx_data", r), 32'(tx_data), 32'(tbl[r].e_data));
            @(negedge clk);
        end
        btn_tick = '0; clr_err = 1'b0; tx_done_tick = 1'b0;

        // Timeout: withhold done, then the other pending channel is granted.
        btn_tick = 4'b0110;
        @(negedge clk);
        btn_tick = '0;
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!tx_start && cnt < 10);
        chk("to_first_latency", 32'(cnt), 1);
        chk("to_first_data", 32'(tx_data), 32'h42);
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!tx_timeout && cnt < 40);
        chk("to_latency", 32'(cnt), 17);
        chk("to_busy_after", 32'(busy), 0);
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!tx_start && cnt < 10);
        chk("to_regrant_latency", 32'(cnt), 1);
        chk("to_regrant_data", 32'(tx_data), 32'h43);
        @(negedge clk); @(negedge clk);
        tx_done_tick = 1'b1; clr_err = 1'b1;
        @(posedge clk); #1;
        chk("to_cleared", 32'(tx_timeout), 0);
        chk("to_done_idle", 32'(busy), 0);
        @(negedge clk);
        tx_done_tick = 1'b0; clr_err = 1'b0;

        // Reset asserted in the middle of a WAIT.
        btn_tick = 4'b0001; @(negedge clk);
        btn_tick = 4'b0000; @(negedge clk);
        btn_tick = 4'b1000; @(negedge clk);
        btn_tick = 4'b1000; @(negedge clk);
        btn_tick = 4'b0000;
        chk("rst_pre_overrun", 32'(overrun), 32'h8);
        chk("rst_pre_busy", 32'(busy), 1);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("rst_async");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b1;
        @(posedge clk); #1;
        chk("rst_late_done_busy", 32'(busy), 0);
        chk("rst_late_done_start", 32'(tx_start), 0);
        @(negedge clk);
        tx_done_tick = 1'b0;
        @(posedge clk); #1;
        chk("rst_idle_start", 32'(tx_start), 0);
        @(negedge clk);

        // Randomized traffic; early phase keeps ch0/ch1 re-ticking for fairness.
        reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
        model_reset();
        countdown = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < int'(N); i++)
                b[i] = (cyc < 600 && i < 2) ? ($urandom_range(0, 99) < 30)
                                            : ($urandom_range(0, 99) < 5);
            c = ($urandom_range(0, 49) == 0);
            d = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) d = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                d = 1'b1;
            end
            btn_tick = b; clr_err = c; tx_done_tick = d;
            @(posedge clk);
            model_step(b, c, d);
            #1;
            model_check();
            if (tx_start)
                countdown = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
